// File: rtl/aip_slave_if.sv
// AIP host-protocol responder: pointers, config/STATUS registers, start/done handshake, interrupt.
// Optional macro AIP_INT_EN adds the interrupt mask register and the active-low int_req.
module aip_slave_if #(
    parameter int          DATAWIDTH = 32,
    parameter int          MEM_AW    = 4,
    parameter int          MEM_DEPTH = 9,
    parameter logic [31:0] IP_ID     = 32'h1000500A
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic                 en_s,
    input  logic [DATAWIDTH-1:0] data_in,
    output logic [DATAWIDTH-1:0] data_out,
    input  logic                 write,
    input  logic                 read,
    input  logic                 start,
    input  logic [4:0]           conf_dbus,
    output logic                 x_we,
    output logic                 y_we,
    output logic [MEM_AW-1:0]    x_addr,
    output logic [MEM_AW-1:0]    y_addr,
    output logic [DATAWIDTH-1:0] x_wdata,
    output logic [DATAWIDTH-1:0] y_wdata,
    output logic [MEM_AW-1:0]    z_addr,
    input  logic [DATAWIDTH-1:0] z_rdata,
    output logic [DATAWIDTH-1:0] conf_size,
    output logic                 start_core,
    input  logic                 core_done,
    output logic                 int_req
);

    localparam logic [4:0] C_MDATA_X = 5'd0;
    localparam logic [4:0] C_ADATA_X = 5'd1;
    localparam logic [4:0] C_MDATA_Y = 5'd2;
    localparam logic [4:0] C_ADATA_Y = 5'd3;
    localparam logic [4:0] C_MDATA_Z = 5'd4;
    localparam logic [4:0] C_ADATA_Z = 5'd5;
    localparam logic [4:0] C_CSIZE   = 5'd6;
    localparam logic [4:0] C_ASIZE   = 5'd7;
    localparam logic [4:0] C_STATUS  = 5'd30;
    localparam logic [4:0] C_IP_ID   = 5'd31;

    localparam logic [MEM_AW-1:0] PTR_LAST  = MEM_AW'(MEM_DEPTH - 1);
    localparam logic [MEM_AW:0]   DEPTH_EXT = (MEM_AW + 1)'(MEM_DEPTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            state, state_next;
    logic [MEM_AW-1:0] px, py, pz;
    logic              pc;
    logic [7:0]        flags;
    logic [7:0]        mask;
    logic              busy;
    logic              launch;
    logic [DATAWIDTH-1:0] rd_data;
    logic [31:0]       status;

    // Strobes are single-cycle qualifiers: each high cycle with en_s=1 is one
    // transfer; write has priority, so a simultaneous read is discarded.
    logic wr_ev, rd_ev, go_ev, done_ev;
    assign wr_ev   = en_s & write;
    assign rd_ev   = en_s & read & ~write;
    assign go_ev   = en_s & start;
    assign done_ev = en_s & core_done;

    function automatic logic [MEM_AW-1:0] ptr_inc(input logic [MEM_AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [MEM_AW-1:0] ptr_load(input logic [MEM_AW-1:0] v);
        return ({1'b0, v} >= DEPTH_EXT) ? '0 : v;
    endfunction

    assign x_we    = wr_ev & (conf_dbus == C_MDATA_X);
    assign y_we    = wr_ev & (conf_dbus == C_MDATA_Y);
    assign x_addr  = px;
    assign y_addr  = py;
    assign x_wdata = data_in;
    assign y_wdata = data_in;
    assign z_addr  = pz;

    assign status = {8'd0, mask, 7'd0, busy, flags};

    always_comb begin
        rd_data = '0;
        case (conf_dbus)
            C_ADATA_X: rd_data = DATAWIDTH'(px);
            C_ADATA_Y: rd_data = DATAWIDTH'(py);
            C_MDATA_Z: rd_data = z_rdata;
            C_ADATA_Z: rd_data = DATAWIDTH'(pz);
            C_CSIZE:   rd_data = conf_size;
            C_ASIZE:   rd_data = DATAWIDTH'(pc);
            C_STATUS:  rd_data = DATAWIDTH'(status);
            C_IP_ID:   rd_data = DATAWIDTH'(IP_ID);
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            data_out  <= '0;
            px        <= '0;
            py        <= '0;
            pz        <= '0;
            pc        <= 1'b0;
            conf_size <= '0;
        end else begin
            if (wr_ev) begin
                case (conf_dbus)
                    C_MDATA_X: px <= ptr_inc(px);
                    C_ADATA_X: px <= ptr_load(data_in[MEM_AW-1:0]);
                    C_MDATA_Y: py <= ptr_inc(py);
                    C_ADATA_Y: py <= ptr_load(data_in[MEM_AW-1:0]);
                    C_ADATA_Z: pz <= ptr_load(data_in[MEM_AW-1:0]);
                    // PC is a one-bit offset: any nonzero legal load saturates it.
                    C_ASIZE:   pc <= (ptr_load(data_in[MEM_AW-1:0]) != '0);
                    C_CSIZE: begin
                        if (!pc) conf_size <= data_in;
                        pc <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (rd_ev) begin
                data_out <= rd_data;
                if (conf_dbus == C_MDATA_Z) pz <= ptr_inc(pz);
            end
        end
    end

    // A DONE set in the same cycle as a host clear wins.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~((wr_ev && conf_dbus == C_STATUS) ? data_in[7:0] : 8'd0))
                     | {7'd0, done_ev};
        end
    end

`ifdef AIP_INT_EN
    always_ff @(posedge clk) begin
        if (rst_a) mask <= '0;
        else if (wr_ev && conf_dbus == C_STATUS) mask <= data_in[23:16];
    end
    assign int_req = ~|(flags & mask);
`else
    assign mask    = '0;
    assign int_req = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state      <= ST_IDLE;
            start_core <= 1'b0;
        end else begin
            state      <= state_next;
            start_core <= launch;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (go_ev)   state_next = ST_RUN;
            ST_RUN:  if (done_ev) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_RUN);
        launch = (state == ST_IDLE) && go_ev;
    end

endmodule

// File: tb/tb_aip_slave_if.sv
// Self-checking bench for aip_slave_if: randomized host traffic against a behavioural model.
module tb_aip_slave_if;

    logic        clk = 1'b0;
    logic        rst_a, en_s, write, read, start, core_done;
    logic [31:0] data_in, data_out, x_wdata, y_wdata, z_rdata, conf_size;
    logic [4:0]  conf_dbus;
    logic        x_we, y_we, start_core, int_req;
    logic [3:0]  x_addr, y_addr, z_addr;

    logic [31:0] z_mem [0:15];
    assign z_rdata = z_mem[z_addr];

    int total = 0;
    int bad   = 0;

`ifdef AIP_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif
    localparam int DEPTH = 9;

    // Reference model state
    int          m_px, m_py, m_pz, m_pc;
    logic [31:0] m_csize, m_dout;
    logic [7:0]  m_flags, m_mask;
    logic        m_busy;
    logic [31:0] exp_q[$];

    aip_slave_if dut (
        .clk(clk), .rst_a(rst_a), .en_s(en_s), .data_in(data_in), .data_out(data_out),
        .write(write), .read(read), .start(start), .conf_dbus(conf_dbus),
        .x_we(x_we), .y_we(y_we), .x_addr(x_addr), .y_addr(y_addr),
        .x_wdata(x_wdata), .y_wdata(y_wdata), .z_addr(z_addr), .z_rdata(z_rdata),
        .conf_size(conf_size), .start_core(start_core), .core_done(core_done),
        .int_req(int_req)
    );

    always #5 clk = ~clk;

    function automatic int ptr_ld(input logic [31:0] d);
        int v;
        v = int'(d[3:0]);
        return (v >= DEPTH) ? 0 : v;
    endfunction

    function automatic logic [31:0] m_status();
        return {8'd0, m_mask, 7'd0, m_busy, m_flags};
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] code);
        case (code)
            5'd1:    return 32'(m_px);
            5'd3:    return 32'(m_py);
            5'd4:    return z_mem[m_pz];
            5'd5:    return 32'(m_pz);
            5'd6:    return m_csize;
            5'd7:    return 32'(m_pc);
            5'd30:   return m_status();
            5'd31:   return 32'h1000500A;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_px = 0; m_py = 0; m_pz = 0; m_pc = 0;
        m_csize = '0; m_dout = '0; m_flags = '0; m_mask = '0; m_busy = 1'b0;
    endtask

    // Called at a falling edge; holds the strobe across one rising edge.
    task automatic bus_write(input logic [4:0] code, input logic [31:0] d);
        conf_dbus = code; data_in = d; write = 1'b1;
        #1;
        total++;
        if (code == 5'd0) begin
            if (x_we !== 1'b1 || x_addr !== 4'(m_px) || x_wdata !== d || y_we !== 1'b0) begin
                bad++;
                $display("FAIL x_write: we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         x_we, x_addr, x_wdata, m_px, d);
            end
        end else if (code == 5'd2) begin
            if (y_we !== 1'b1 || y_addr !== 4'(m_py) || y_wdata !== d || x_we !== 1'b0) begin
                bad++;
                $display("FAIL y_write: we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         y_we, y_addr, y_wdata, m_py, d);
            end
        end else if (x_we !== 1'b0 || y_we !== 1'b0) begin
            bad++;
            $display("FAIL spurious_we: x_we=%b y_we=%b want 0 0 (code %0d)", x_we, y_we, code);
        end
        @(negedge clk);
        write = 1'b0;
        case (code)
            5'd0: m_px = (m_px + 1) % DEPTH;
            5'd1: m_px = ptr_ld(d);
            5'd2: m_py = (m_py + 1) % DEPTH;
            5'd3: m_py = ptr_ld(d);
            5'd5: m_pz = ptr_ld(d);
            5'd6: begin
                if (m_pc == 0) m_csize = d;
                m_pc = 1;
            end
            5'd7: m_pc = (ptr_ld(d) != 0) ? 1 : 0;
            5'd30: begin
                m_mask  = INT_EN ? d[23:16] : 8'd0;
                m_flags = m_flags & ~d[7:0];
            end
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [4:0] code);
        logic [31:0] exp;
        conf_dbus = code; read = 1'b1;
        exp = exp_read(code);
        if (code == 5'd4) m_pz = (m_pz + 1) % DEPTH;
        @(negedge clk);
        read = 1'b0;
        m_dout = exp;
        total++;
        if (data_out !== exp) begin
            bad++;
            $display("FAIL read_code%0d: got %h want %h", code, data_out, exp);
        end
    endtask

    task automatic check_irq(input string name);
        logic exp;
        exp = ~|(m_flags & m_mask);
        total++;
        if (int_req !== exp) begin
            bad++;
            $display("FAIL %s: int_req=%b want %b", name, int_req, exp);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        model_reset();
        total++;
        if (data_out !== 32'd0 || start_core !== 1'b0 || x_we !== 1'b0 ||
            y_we !== 1'b0 || conf_size !== 32'd0 || z_addr !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs: dout=%h sc=%b xwe=%b ywe=%b csize=%h zaddr=%0d want all 0",
                     data_out, start_core, x_we, y_we, conf_size, z_addr);
        end
        check_irq("reset_int_req");
        bus_read(5'd31);
        bus_read(5'd30);
        bus_read(5'd1);
        bus_read(5'd12);
    endtask

    task automatic test_mem_x();
        bus_write(5'd1, 32'd0);
        for (int i = 1; i <= 5; i++) bus_write(5'd0, 32'(i));
        bus_read(5'd1);
        bus_write(5'd1, 32'd7);
        for (int i = 0; i < 3; i++) bus_write(5'd0, $urandom);
        bus_read(5'd1);
        bus_write(5'd1, 32'd12);
        bus_read(5'd1);
        bus_write(5'd3, 32'd8);
        for (int i = 0; i < 2; i++) bus_write(5'd2, $urandom);
        bus_read(5'd3);
    endtask

    task automatic test_conf();
        bus_write(5'd6, 32'h000000A5);
        total++;
        if (conf_size !== 32'hA5) begin
            bad++;
            $display("FAIL csize_first: got %h want %h", conf_size, 32'hA5);
        end
        bus_write(5'd6, 32'h12345678);
        total++;
        if (conf_size !== 32'hA5) begin
            bad++;
            $display("FAIL csize_dropped: got %h want %h", conf_size, 32'hA5);
        end
        bus_read(5'd7);
        bus_write(5'd7, 32'd0);
        bus_write(5'd6, 32'h0000005A);
        bus_read(5'd6);
    endtask

    task automatic test_fsm();
        bus_write(5'd30, 32'h00010000);
        start = 1'b1;
        #1;
        total++;
        if (start_core !== 1'b0) begin
            bad++;
            $display("FAIL start_early: start_core=%b want 0", start_core);
        end
        @(negedge clk);
        start = 1'b0;
        m_busy = 1'b1;
        total++;
        if (start_core !== 1'b1) begin
            bad++;
            $display("FAIL start_pulse: start_core=%b want 1", start_core);
        end
        bus_read(5'd30);
        total++;
        if (start_core !== 1'b0) begin
            bad++;
            $display("FAIL start_width: start_core=%b want 0", start_core);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (start_core !== 1'b0) begin
            bad++;
            $display("FAIL start_in_run: start_core=%b want 0", start_core);
        end
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        m_flags = 8'h01;
        m_busy  = 1'b0;
        check_irq("done_int_req");
        bus_read(5'd30);
        bus_write(5'd30, 32'h00010001);
        check_irq("clear_int_req");
        bus_read(5'd30);
        core_done = 1'b1;
        bus_write(5'd30, 32'h00010001);
        core_done = 1'b0;
        m_flags = 8'h01;
        bus_read(5'd30);
        check_irq("set_wins_int_req");
        bus_write(5'd30, 32'h00000001);
        check_irq("mask_off_int_req");
        en_s = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        en_s = 1'b1;
        @(negedge clk);
        total++;
        if (start_core !== 1'b0) begin
            bad++;
            $display("FAIL start_disabled: start_core=%b want 0", start_core);
        end
        bus_read(5'd30);
    endtask

    task automatic test_enable_and_conflict();
        en_s = 1'b0;
        conf_dbus = 5'd0; data_in = 32'hDEAD0001; write = 1'b1;
        #1;
        total++;
        if (x_we !== 1'b0) begin
            bad++;
            $display("FAIL we_disabled: x_we=%b want 0", x_we);
        end
        @(negedge clk);
        write = 1'b0; en_s = 1'b1;
        bus_read(5'd1);
        conf_dbus = 5'd1; data_in = 32'd3; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        m_px = 3;
        total++;
        if (data_out !== m_dout) begin
            bad++;
            $display("FAIL rw_conflict: data_out=%h want %h", data_out, m_dout);
        end
        bus_read(5'd1);
    endtask

    task automatic test_back_to_back();
        bus_write(5'd5, 32'd0);
        for (int i = 0; i < 9; i++) exp_q.push_back(z_mem[i % DEPTH]);
        for (int i = 0; i < 9; i++) begin
            logic [31:0] e;
            bus_read(5'd4);
            e = exp_q.pop_front();
            total++;
            if (data_out !== e) begin
                bad++;
                $display("FAIL z_stream[%0d]: got %h want %h", i, data_out, e);
            end
        end
        bus_read(5'd5);
        bus_read(5'd4);
        bus_read(5'd4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_a = 1'b1; conf_dbus = 5'd4; read = 1'b1; core_done = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; read = 1'b0; core_done = 1'b0;
        model_reset();
        total++;
        if (data_out !== 32'd0 || z_addr !== 4'd0 || start_core !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: dout=%h zaddr=%0d sc=%b want 0 0 0", data_out, z_addr, start_core);
        end
        check_irq("mid_reset_int_req");
        bus_read(5'd30);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 6))
                0: bus_write(5'd0, $urandom);
                1: bus_write(5'd2, $urandom);
                2: bus_write(5'd1, 32'($urandom_range(0, 15)));
                3: bus_write(5'd3, 32'($urandom_range(0, 15)));
                4: bus_read(5'd4);
                5: bus_read(5'(2 * $urandom_range(0, 2) + 1));
                default: bus_write(5'd5, 32'($urandom_range(0, 15)));
            endcase
        end
    endtask

    initial begin
        rst_a = 1'b1; en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0;
        core_done = 1'b0; conf_dbus = '0; data_in = '0;
        for (int i = 0; i < 16; i++) z_mem[i] = $urandom;
        model_reset();
        @(negedge clk);
        test_reset();
        test_mem_x();
        test_conf();
        test_fsm();
        test_enable_and_conflict();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

endmodule
